// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target register interface.
//   i2c_state_t  - target FSM state encoding
//   I2C_WR/I2C_RD - R/W bit values of the address byte
//   ACK/NAK       - acknowledge bit values on SDA
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_REG_H,
    ST_ACK_H,
    ST_REG_L,
    ST_ACK_L,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;
  localparam logic ACK    = 1'b0;
  localparam logic NAK    = 1'b1;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: synchronises SCL/SDA into the clk domain and decodes bus events.
//   clk, rst_n   - system clock, async active-low reset
//   i_scl, i_sda - raw bus lines
//   o_sda        - synchronised SDA level
//   o_scl_pos    - one-cycle pulse on SCL rising edge
//   o_scl_neg    - one-cycle pulse on SCL falling edge
//   o_start_det  - START / repeated START (SDA falls while SCL high)
//   o_stop_det   - STOP (SDA rises while SCL high)
module i2c_bus_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_pos,
  output logic o_scl_neg,
  output logic o_start_det,
  output logic o_stop_det
);

  // [0] metastability flop, [1] synchronised level, [2] previous level
  logic [2:0] r_scl_pipe;
  logic [2:0] r_sda_pipe;
  logic       w_sda_pos;
  logic       w_sda_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_pipe <= '1;
      r_sda_pipe <= '1;
    end else begin
      r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
      r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
    end
  end

  assign o_sda       = r_sda_pipe[1];
  assign o_scl_pos   = r_scl_pipe[1] & ~r_scl_pipe[2];
  assign o_scl_neg   = ~r_scl_pipe[1] & r_scl_pipe[2];
  assign w_sda_pos   = r_sda_pipe[1] & ~r_sda_pipe[2];
  assign w_sda_neg   = ~r_sda_pipe[1] & r_sda_pipe[2];
  assign o_start_det = w_sda_neg & r_scl_pipe[1];
  assign o_stop_det  = w_sda_pos & r_scl_pipe[1];

endmodule

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target for 16-bit register address / 8-bit data access.
//   clk, rst_n - system clock, async active-low reset
//   scl        - bus clock (input only, no stretching)
//   sda        - open-drain bus data (driven 0 or z)
//   reg_addr   - current register address {addr_H, addr_L}
//   wr_en      - one-cycle write strobe, wr_data valid with it
//   rd_en      - one-cycle read request; rd_data valid on the following edge
//   busy       - address-matched transfer in progress (until STOP)
//   stop_det   - one-cycle pulse per STOP
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  logic        sda,
  output logic [15:0] reg_addr,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        stop_det
);

  logic w_sda_s, w_scl_pos, w_scl_neg, w_start, w_stop;

  i2c_bus_cond u_bus_cond (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_scl       (scl),
    .i_sda       (sda),
    .o_sda       (w_sda_s),
    .o_scl_pos   (w_scl_pos),
    .o_scl_neg   (w_scl_neg),
    .o_start_det (w_start),
    .o_stop_det  (w_stop)
  );

  i2c_state_t  r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_sda_oe;
  logic [15:0] r_reg_addr;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic        r_rd_en;
  logic        r_busy;
  logic        r_mack;
  logic [1:0]  r_ld;

  logic w_bus_evt, w_byte_done, w_addr_hit, w_byte_end;
  logic w_rx_shift, w_cnt_inc, w_ack_on, w_slot_end, w_match;
  logic w_load_h, w_load_l, w_wr_fire, w_inc;
  logic w_ld_step, w_tx_load, w_tx_shift, w_tx_end, w_mack_smp;

  assign w_bus_evt   = w_start | w_stop;
  assign w_byte_done = (r_bit_cnt == BITS_PER_BYTE);
  assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);
  assign w_byte_end  = w_scl_neg & w_byte_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_DEV_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_DEV_ADDR: if (w_byte_end) w_state_nxt = w_addr_hit ? ST_ACK_DEV : ST_IGNORE;
        // r_shift still holds the address byte here; bit 0 is R/W
        ST_ACK_DEV:  if (w_scl_neg) w_state_nxt = (r_shift[0] == I2C_WR) ? ST_REG_H : ST_RD_LOAD;
        ST_REG_H:    if (w_byte_end) w_state_nxt = ST_ACK_H;
        ST_ACK_H:    if (w_scl_neg) w_state_nxt = ST_REG_L;
        ST_REG_L:    if (w_byte_end) w_state_nxt = ST_ACK_L;
        ST_ACK_L:    if (w_scl_neg) w_state_nxt = ST_WR_DATA;
        ST_WR_DATA:  if (w_byte_end) w_state_nxt = ST_ACK_WR;
        ST_ACK_WR:   if (w_scl_neg) w_state_nxt = ST_WR_DATA;
        ST_RD_LOAD:  if (r_ld == 2'd2) w_state_nxt = ST_RD_DATA;
        ST_RD_DATA:  if (w_byte_end) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK:   if (w_scl_neg) w_state_nxt = (r_mack == ACK) ? ST_RD_LOAD : ST_IGNORE;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state datapath controls
  always_comb begin
    w_rx_shift = 1'b0;
    w_cnt_inc  = 1'b0;
    w_ack_on   = 1'b0;
    w_slot_end = 1'b0;
    w_match    = 1'b0;
    w_load_h   = 1'b0;
    w_load_l   = 1'b0;
    w_wr_fire  = 1'b0;
    w_inc      = 1'b0;
    w_ld_step  = 1'b0;
    w_tx_load  = 1'b0;
    w_tx_shift = 1'b0;
    w_tx_end   = 1'b0;
    w_mack_smp = 1'b0;
    if (!w_bus_evt) begin
      case (r_state)
        ST_DEV_ADDR, ST_REG_H, ST_REG_L, ST_WR_DATA: begin
          w_rx_shift = w_scl_pos;
          w_cnt_inc  = w_scl_pos & ~w_byte_done;
          w_match    = (r_state == ST_DEV_ADDR) & w_byte_end & w_addr_hit;
          w_load_h   = (r_state == ST_REG_H)    & w_byte_end;
          w_load_l   = (r_state == ST_REG_L)    & w_byte_end;
          w_wr_fire  = (r_state == ST_WR_DATA)  & w_byte_end;
          w_ack_on   = w_match | w_load_h | w_load_l | w_wr_fire;
        end
        ST_ACK_DEV, ST_ACK_H, ST_ACK_L: w_slot_end = w_scl_neg;
        ST_ACK_WR: begin
          w_slot_end = w_scl_neg;
          w_inc      = w_scl_neg & AUTO_INC;
        end
        // Three cycles: issue rd_en, wait for the register file, capture
        ST_RD_LOAD: begin
          w_ld_step = (r_ld != 2'd2);
          w_tx_load = (r_ld == 2'd2);
        end
        ST_RD_DATA: begin
          w_cnt_inc  = w_scl_pos & ~w_byte_done;
          w_tx_shift = w_scl_neg & ~w_byte_done;
          w_tx_end   = w_byte_end;
        end
        ST_RD_ACK: begin
          w_mack_smp = w_scl_pos;
          w_slot_end = w_scl_neg;
          w_inc      = w_scl_neg & AUTO_INC & (r_mack == ACK);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_mack     <= NAK;
      r_ld       <= '0;
    end else begin
      r_wr_en <= w_wr_fire;
      r_rd_en <= w_ld_step & (r_ld == 2'd0);
      if (w_bus_evt) begin
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_ld      <= '0;
      end else begin
        if (w_rx_shift) r_shift <= {r_shift[6:0], w_sda_s};
        if (w_cnt_inc)  r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_slot_end) begin
          r_bit_cnt <= '0;
          r_sda_oe  <= 1'b0;
        end
        if (w_ack_on)   r_sda_oe <= 1'b1;
        if (w_load_h)   r_reg_addr[15:8] <= r_shift;
        if (w_load_l)   r_reg_addr[7:0]  <= r_shift;
        if (w_wr_fire)  r_wr_data <= r_shift;
        if (w_inc)      r_reg_addr <= r_reg_addr + 16'd1;
        if (w_ld_step)  r_ld <= r_ld + 2'd1;
        if (w_tx_load) begin
          r_shift  <= rd_data;
          r_sda_oe <= ~rd_data[7];
          r_ld     <= '0;
        end
        if (w_tx_shift) begin
          r_shift  <= {r_shift[6:0], 1'b0};
          r_sda_oe <= ~r_shift[6];
        end
        if (w_tx_end)   r_sda_oe <= 1'b0;
        if (w_mack_smp) r_mack <= w_sda_s;
      end
      if (w_stop)       r_busy <= 1'b0;
      else if (w_match) r_busy <= 1'b1;
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_addr = r_reg_addr;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign rd_en    = r_rd_en;
  assign busy     = r_busy;
  assign stop_det = w_stop;

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- I2C target (responder) that terminates the 16-bit-register-address / 8-bit-data protocol issued by our I2C master core.
- Decodes START, repeated START and STOP, matches a fixed 7-bit device address, latches a 2-byte register address, and then writes or reads data bytes.
- Presents a simple one-cycle-strobe register-bus interface to a local register file.
- Sits on the sensor/bridge side for loopback bring-up and for exposing on-chip CSRs over I2C. No clock stretching; SCL is input-only.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit device address this target acknowledges.
- AUTO_INC, 1, when 1, reg_addr increments after every data byte, in both write and read.

Ports:
- clk  input  1  system clock, 100 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from the bus. Sampled only; never driven.
- sda  inout  1  I2C data. Open-drain: driven 1'b0 or 1'bz, never 1.
- reg_addr  output  16  current register address, {addr_H, addr_L}.
- wr_en  output  1  one-cycle write strobe.
- wr_data  output  8  write byte, valid while wr_en=1.
- rd_en  output  1  one-cycle read-request strobe.
- rd_data  input  8  read byte; must be valid on the clk edge following rd_en (1-cycle register-file latency).
- busy  output  1  high from an address-matched START to the next STOP.
- stop_det  output  1  one-cycle pulse on every detected STOP.

Behaviour:
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer (reset value 1), then a third flop for edge detection.
  - scl_pos/scl_neg and sda_pos/sda_neg are single-cycle pulses.
- Bus conditions:
  - START = sda_neg while synchronized scl=1.
  - STOP = sda_pos while synchronized scl=1.
  - Both have priority over every state. START (including repeated START) forces DEV_ADDR and clears the bit counter. STOP forces IDLE.
- Data timing: receive bits are sampled on scl_pos, MSB first. Output SDA changes only on scl_neg.
- bit_cnt counts 0..8 and is cleared on START and at the end of each ACK slot.
- FSM states: IDLE, DEV_ADDR, ACK_DEV, REG_H, ACK_H, REG_L, ACK_L, WR_DATA, ACK_WR, RD_LOAD, RD_DATA, RD_ACK, IGNORE.
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits.
    - On the 8th scl_neg: if addr[7:1]==DEV_ADDR, go to ACK_DEV and drive sda low. Otherwise go to IGNORE and keep sda released.
  - ACK_DEV: on scl_neg, release sda.
    - R/W=0 goes to REG_H.
    - R/W=1 goes to RD_LOAD, using the current reg_addr (the address set by the previous write phase).
  - REG_H → ACK_H → REG_L → ACK_L: each address byte is acked.
    - reg_addr[15:8] is loaded at the end of REG_H; reg_addr[7:0] at the end of REG_L.
    - ACK_L goes to WR_DATA.
  - WR_DATA: on the 8th bit, drive ACK and pulse wr_en with wr_data at the ACK-slot scl_neg. Go to ACK_WR.
  - ACK_WR: on scl_neg, release sda.
    - If AUTO_INC, reg_addr++ (16-bit wrap, 16'hFFFF→16'h0000).
    - Return to WR_DATA.
    - A repeated START here switches to a read without changing reg_addr. This is the master's address-then-read sequence.
  - RD_LOAD: pulse rd_en for 1 cycle, capture rd_data into the shift register on the next clk, drive bit7 immediately, then go to RD_DATA.
  - RD_DATA: on each scl_neg, shift out the next bit. After 8 bits, release sda and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_pos.
    - On the following scl_neg: ACK(0) means reg_addr++ if AUTO_INC, then RD_LOAD.
    - NAK(1) means IGNORE.
  - IGNORE: sda released; wait for START or STOP.
- ACK drive: sda is pulled low from the scl_neg ending bit 8 until the scl_neg ending the ACK slot.
- Reset values: sda released (z), reg_addr=0, wr_en=0, wr_data=0, rd_en=0, busy=0, stop_det=0, FSM=IDLE.
- Reset mid-transfer releases sda immediately (asynchronous). reg_addr is also reset.
- Assumption: SCL low half-period is at least 4 clk cycles; the master core provides ~170.
- The general-call address is not supported; it is treated as a mismatch.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encoding.
  - I2C_WR=0 / I2C_RD=1 R/W bit constants.
  - ACK=0 / NAK=1.
- One natural sub-module: i2c_bus_cond.
  - Synchronizers and edge detect.
  - Outputs scl_pos, scl_neg, start_det, stop_det.
  - Shareable with the master core.

Test Plan:
- Write: START, 0x78, 0x12, 0x34, 0xA5, STOP → ACK on all four bytes; one wr_en with reg_addr=16'h1234, wr_data=8'hA5; stop_det pulses once; busy ends 0.
- Burst write: 0x78, 0x00, 0xFE, 0x11, 0x22, 0x33 → wr_en three times at addresses 0x00FE, 0x00FF, 0x0100 with the data in order.
- Read: START, 0x78, 0x43, 0x21, then repeated START, 0x79, then one byte with NAK, then STOP; register file returns 8'h5C for 0x4321 → exactly one rd_en with reg_addr=16'h4321; sda carries 0x5C MSB first.
- Wrong address: START, 0x7A, … → sda never pulled low, no wr_en/rd_en, busy=0; FSM back in IDLE after STOP.
- Read burst with master ACK, ACK, NAK at start address 16'hFFFF → rd_en at 0xFFFF, 0x0000, 0x0001 (address wrap), then sda released.
- rst_n asserted during the ACK slot of the REG_H byte → sda released in the same cycle; all outputs reach their reset values; next full write transaction completes normally.
